mult_share_arbiter: RTL and testbench

- Shares one instance of the team's 8x8 combinational array multiplier (a, b -> 16-bit product) among NREQ requesters.
- A round-robin arbiter grants one requester at a time. The FSM registers that requester's operands, captures the product one cycle later, and holds the result until the consumer accepts it.
- Sits between the KGPRisc execute-stage clients (ALU MUL path, address-scaling unit, debug port) and the shared multiplier.

---
 rtl/mult_share_arbiter.sv | 113 +++++++++++
 tb/tb_mult_share_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 8x8 unsigned array multiplier among NREQ requesters.
// One operation in flight; the result is held until the consumer accepts it.

module mult8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p + ({8'b0, a} << i);
        end
    end
endmodule

module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_product,
    input  logic                rsp_ready,
    output logic                busy
);
    if (W != 8) begin : g_w_check
        $error("mult_share_arbiter: W must be 8");
    end

    localparam int unsigned N = NREQ;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  id;
    logic [W-1:0]    op_a, op_b;
    logic [15:0]     product;

    logic [NREQ-1:0] grant;
    logic            found;
    int unsigned     idx, gidx;
    logic [W-1:0]    sel_a, sel_b;

    mult8x8 u_mult (.a(op_a), .b(op_b), .p(product));

    // Scan starts just after the last winner, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        gidx  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
        sel_a = req_a[gidx*W +: W];
        sel_b = req_b[gidx*W +: W];
    end

    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= IDW'(NREQ - 1);
            id          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id    <= IDW'(gidx);
                        last  <= IDW'(gidx);
                        state <= MUL;
                    end
                end
                MUL: begin
                    rsp_product <= product;
                    rsp_id      <= id;
                    rsp_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with hand-computed expected values.

module tb_mult_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_product;
    logic        rsp_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mult_share_arbiter #(.NREQ(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},  req_ready, 0);
        check({tag, "_rv"},   rsp_valid, 0);
        check({tag, "_id"},   rsp_id, 0);
        check({tag, "_prod"}, rsp_product, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Starts in IDLE with rsp_ready=1; covers grant, MUL, DONE and return to IDLE.
    task automatic run_op(input string tag, input int id, input logic [15:0] prod, input bit hold);
        #1;
        check({tag, "_grant"}, req_ready, 32'(1) << id);
        check({tag, "_idle"},  busy, 0);
        tick();
        check({tag, "_mul_rdy"},  req_ready, 0);
        check({tag, "_mul_busy"}, busy, 1);
        check({tag, "_mul_rv"},   rsp_valid, 0);
        if (!hold) req_valid[id] = 1'b0;
        tick();
        check({tag, "_rv"},   rsp_valid, 1);
        check({tag, "_id"},   rsp_id, id);
        check({tag, "_prod"}, rsp_product, prod);
        tick();
        check({tag, "_rv_clr"}, rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #3;
        check_idle_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;

        // Single op; operand change during MUL must not affect the result
        set_op(0, 8'd3, 8'd5);
        req_valid = 4'b0001;
        #1;
        check("single_grant", req_ready, 4'b0001);
        tick();
        check("single_mul_rdy", req_ready, 0);
        check("single_busy", busy, 1);
        req_valid = '0;
        set_op(0, 8'd99, 8'd99);
        tick();
        check("single_rv", rsp_valid, 1);
        check("single_id", rsp_id, 0);
        check("single_prod", rsp_product, 15);
        rsp_ready = 1'b1;
        tick();
        check("single_rv_clr", rsp_valid, 0);
        check("single_busy_clr", busy, 0);

        // Operand extremes
        set_op(0, 8'd255, 8'd255); req_valid = 4'b0001;
        run_op("max", 0, 16'd65025, 0);
        set_op(1, 8'd0, 8'd200);   req_valid = 4'b0010;
        run_op("zero", 1, 16'd0, 0);
        set_op(3, 8'd128, 8'd2);   req_valid = 4'b1000;
        run_op("p256", 3, 16'd256, 0);

        // Full contention: strict rotation, one grant per 3 cycles
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd10);
        req_valid = 4'b1111;
        run_op("rr0", 0, 16'd10, 1);
        run_op("rr1", 1, 16'd20, 1);
        run_op("rr2", 2, 16'd30, 1);
        run_op("rr3", 3, 16'd40, 1);
        run_op("rr4", 0, 16'd10, 1);
        req_valid = '0;

        // Backpressure: result held, no grants while stalled in DONE
        rsp_ready = 1'b0;
        set_op(0, 8'd6, 8'd7);
        req_valid = 4'b0001;
        #1;
        check("bp_grant", req_ready, 4'b0001);
        tick();
        set_op(1, 8'd2, 8'd3);
        set_op(2, 8'd4, 8'd5);
        req_valid = 4'b0110;
        tick();
        for (int c = 0; c < 6; c++) begin
            check("bp_rv",   rsp_valid, 1);
            check("bp_id",   rsp_id, 0);
            check("bp_prod", rsp_product, 42);
            check("bp_rdy",  req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hold_rdy", req_ready, 0);
        tick();
        check("bp_rv_clr", rsp_valid, 0);
        run_op("bp_r1", 1, 16'd6, 0);
        run_op("bp_r2", 2, 16'd20, 0);

        // Fairness: req0 stays asserted, req2 must be served by the 2nd grant
        set_op(0, 8'd11, 8'd11);
        set_op(2, 8'd12, 8'd12);
        req_valid = 4'b0101;
        run_op("fair0", 0, 16'd121, 1);
        run_op("fair2", 2, 16'd144, 0);
        req_valid = '0;

        // Withdrawn request leaves state untouched
        req_valid = 4'b1000;
        #1;
        check("wd_grant", req_ready, 4'b1000);
        req_valid = '0;
        tick();
        check("wd_busy", busy, 0);
        check("wd_rv", rsp_valid, 0);

        // Reset during MUL aborts and resets the pointer
        set_op(0, 8'd7, 8'd9);
        req_valid = 4'b0001;
        #1;
        check("rst_grant", req_ready, 4'b0001);
        tick();
        check("rst_in_mul", busy, 1);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        req_valid = 4'b1111;
        tick();
        check("rst_hold_rv", rsp_valid, 0);
        check("rst_hold_rdy", req_ready, 0);
        tick();
        check("rst_hold_rv2", rsp_valid, 0);
        rst_n = 1'b1;
        run_op("post_rst", 0, 16'd63, 1);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
